// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB master: one 16-bit-address register write or read per command
module sccb_master #(
    parameter int CLK_DIV   = 125,
    parameter int ACK_CHECK = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  dev_id,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        ack_err,
    output logic        sccb_clk,
    output logic        sccb_clk_en,
    output logic        sccb_data_out,
    output logic        sccb_data_en,
    input  logic        sccb_data_in
);
    typedef enum logic [2:0] {IDLE, START, TX_BYTE, TX_ACK, STOP, RX_BYTE, RX_NACK, DONE} state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [1:0]  qtr;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic        rd_phase;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  shreg;
    logic [7:0]  cur_byte;
    logic [7:0]  nxt_byte;
    logic        qtr_tick;

    assign qtr_tick = (div_cnt == 16'(CLK_DIV - 1));

    // {scl, sda, sda_release} for quarter q of a phase in state st; b is the outgoing data bit
    function automatic logic [2:0] drive(input state_t st, input logic [1:0] q, input logic b);
        logic mid;
        mid = (q == 2'd1) || (q == 2'd2);
        case (st)
            START:           drive = {q != 2'd3, q < 2'd2, 1'b0};
            TX_BYTE:         drive = {mid, b, 1'b0};
            TX_ACK, RX_BYTE: drive = {mid, 1'b1, 1'b1};
            RX_NACK:         drive = {mid, 1'b1, 1'b0};
            STOP:            drive = {q != 2'd0, q[1], 1'b0};
            default:         drive = 3'b111;
        endcase
    endfunction

    always_comb begin
        cur_byte = wdata_q;
        if (rd_phase) begin
            cur_byte = {dev_q, 1'b1};
        end else begin
            case (byte_cnt)
                2'd0:    cur_byte = {dev_q, 1'b0};
                2'd1:    cur_byte = addr_q[15:8];
                2'd2:    cur_byte = addr_q[7:0];
                default: cur_byte = wdata_q;
            endcase
        end
    end

    always_comb begin
        nxt_byte = wdata_q;
        case (byte_cnt)
            2'd0:    nxt_byte = addr_q[15:8];
            2'd1:    nxt_byte = addr_q[7:0];
            default: nxt_byte = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            div_cnt  <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rd_phase <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            ack_err  <= 1'b0;
            sccb_clk_en <= 1'b0;
            {sccb_clk, sccb_data_out, sccb_data_en} <= 3'b111;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        rw_q     <= rw;
                        dev_q    <= dev_id;
                        addr_q   <= reg_addr;
                        wdata_q  <= wr_data;
                        state    <= START;
                        busy     <= 1'b1;
                        ack_err  <= 1'b0;
                        div_cnt  <= '0;
                        qtr      <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        rd_phase <= 1'b0;
                        sccb_clk_en <= 1'b1;
                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(START, 2'd0, 1'b1);
                    end
                end
                default: begin
                    div_cnt <= div_cnt + 16'd1;
                    if (qtr_tick) begin
                        div_cnt <= '0;
                        if (qtr != 2'd3) begin
                            qtr <= qtr + 2'd1;
                            {sccb_clk, sccb_data_out, sccb_data_en} <= drive(state, qtr + 2'd1, shreg[7]);
                            // SCL has been high for a full quarter at the end of Q2
                            if (qtr == 2'd2) begin
                                if (state == TX_ACK && ACK_CHECK != 0 && sccb_data_in)
                                    ack_err <= 1'b1;
                                if (state == RX_BYTE)
                                    shreg <= {shreg[6:0], sccb_data_in};
                            end
                        end else begin
                            qtr <= 2'd0;
                            case (state)
                                START: begin
                                    state   <= TX_BYTE;
                                    bit_cnt <= '0;
                                    shreg   <= cur_byte;
                                    {sccb_clk, sccb_data_out, sccb_data_en} <= drive(TX_BYTE, 2'd0, cur_byte[7]);
                                end
                                TX_BYTE: begin
                                    if (bit_cnt == 3'd7) begin
                                        state <= TX_ACK;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(TX_ACK, 2'd0, 1'b1);
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        shreg   <= {shreg[6:0], 1'b0};
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(TX_BYTE, 2'd0, shreg[6]);
                                    end
                                end
                                TX_ACK: begin
                                    if (rd_phase) begin
                                        state   <= RX_BYTE;
                                        bit_cnt <= '0;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(RX_BYTE, 2'd0, 1'b1);
                                    end else if (byte_cnt == (rw_q ? 2'd2 : 2'd3)) begin
                                        state <= STOP;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(STOP, 2'd0, 1'b0);
                                    end else begin
                                        state    <= TX_BYTE;
                                        byte_cnt <= byte_cnt + 2'd1;
                                        bit_cnt  <= '0;
                                        shreg    <= nxt_byte;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(TX_BYTE, 2'd0, nxt_byte[7]);
                                    end
                                end
                                RX_BYTE: begin
                                    if (bit_cnt == 3'd7) begin
                                        state <= RX_NACK;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(RX_NACK, 2'd0, 1'b1);
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(RX_BYTE, 2'd0, 1'b1);
                                    end
                                end
                                RX_NACK: begin
                                    state <= STOP;
                                    {sccb_clk, sccb_data_out, sccb_data_en} <= drive(STOP, 2'd0, 1'b0);
                                end
                                STOP: begin
                                    // a read restarts once for the data half of the transfer
                                    if (rw_q && !rd_phase) begin
                                        rd_phase <= 1'b1;
                                        state    <= START;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= drive(START, 2'd0, 1'b1);
                                    end else begin
                                        state       <= DONE;
                                        busy        <= 1'b0;
                                        done        <= 1'b1;
                                        sccb_clk_en <= 1'b0;
                                        {sccb_clk, sccb_data_out, sccb_data_en} <= 3'b111;
                                        if (rw_q)
                                            rd_data <= shreg;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule
